// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: default address width,
// conditional-branch opcodes and the branch resolve unit state encoding.
package mips_pkg;

   // Default PC / address width
   localparam int AW_DEF = 32;

   // Conditional branch primary opcodes
   localparam logic [5:0] OP_REGIMM = 6'h1;
   localparam logic [5:0] OP_BEQ    = 6'h4;
   localparam logic [5:0] OP_BNE    = 6'h5;
   localparam logic [5:0] OP_BLEZ   = 6'h6;
   localparam logic [5:0] OP_BGTZ   = 6'h7;

   // Branch resolve unit state: normal resolution, or one-cycle wrong-path drain
   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bruState_t;

   // True when the primary opcode is one of the conditional branches
   function automatic logic isBranchOp(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
             (op == OP_BGTZ) || (op == OP_REGIMM);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous clear. Sticks at all-ones.
module bru_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, hold at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: carries the fetch-time prediction into D,
// compares it with the resolved outcome, drives redirect/flush on a miss,
// and returns a registered training update to the predictor.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined;
// otherwise BrCnt/MissCnt are tied to zero.
module branch_resolve_unit
   import mips_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             PreBrF,
   input  logic [AW-1:0]    PCPredictF,
   input  logic [AW-1:0]    PCPlus4F,
   input  logic             BranchD,
   input  logic             BrTakenD,
   input  logic [AW-1:0]    PCBranchD,
   output logic             MispredD,
   output logic [AW-1:0]    RedirectPCD,
   output logic             FlushFD,
   output logic             UpdEn,
   output logic             UpdTaken,
   output logic [AW-1:0]    UpdTarget,
   output logic [CNT_W-1:0] BrCnt,
   output logic [CNT_W-1:0] MissCnt
);

   bruState_t      stateReg;
   bruState_t      stateNext;

   logic           preD;
   logic [AW-1:0]  predPCD;
   logic [AW-1:0]  pc4D;

   logic           res;

   // D-stage copy of the fetch prediction; any flush wins over a stall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         preD    <= 1'b0;
         predPCD <= '0;
         pc4D    <= '0;
      end else if (FlushD || FlushFD) begin
         preD    <= 1'b0;
         predPCD <= '0;
         pc4D    <= '0;
      end else if (!StallD) begin
         preD    <= PreBrF;
         predPCD <= PCPredictF;
         pc4D    <= PCPlus4F;
      end
   end

   // Resolve the D-stage branch and pick the corrected fetch PC on a miss
   always_comb begin
      res         = rst_n & BranchD & ~StallD & (stateReg == RUN);
      MispredD    = 1'b0;
      RedirectPCD = '0;
      if (res) begin
         if (preD && !BrTakenD) begin
            MispredD    = 1'b1;
            RedirectPCD = pc4D;
         end else if (!preD && BrTakenD) begin
            MispredD    = 1'b1;
            RedirectPCD = PCBranchD;
         end else if (preD && BrTakenD && (predPCD != PCBranchD)) begin
            MispredD    = 1'b1;
            RedirectPCD = PCBranchD;
         end
      end
      FlushFD = MispredD;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg <= RUN;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next state: a miss drains one wrong-path D slot; a stall stretches the drain
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         RUN:     if (MispredD) stateNext = RECOVER;
         RECOVER: if (!StallD)  stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   // Training pulse one cycle after each resolution; payload holds otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         UpdEn     <= 1'b0;
         UpdTaken  <= 1'b0;
         UpdTarget <= '0;
      end else begin
         UpdEn <= res;
         if (res) begin
            UpdTaken  <= BrTakenD;
            UpdTarget <= PCBranchD;
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   // Index 0 counts resolved branches, index 1 counts mispredictions
   logic [1:0]       cntInc;
   logic [CNT_W-1:0] cntVal [2];

   assign cntInc = {MispredD, res};

   for (genvar gi = 0; gi < 2; gi++) begin : gPerfCnt
      bru_sat_counter #(
         .CNT_W(CNT_W)
      ) uCnt (
         .clk  (clk),
         .clr  (~rst_n),
         .inc  (cntInc[gi]),
         .count(cntVal[gi])
      );
   end

   assign BrCnt   = cntVal[0];
   assign MissCnt = cntVal[1];
`else
   assign BrCnt   = '0;
   assign MissCnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Decode-stage counterpart to the fetch-stage predictor.
- Carries each fetch-time prediction (taken flag and predicted target) into D alongside the instruction.
- Compares the prediction with the real branch outcome resolved in D. On mismatch it drives the PC redirect and the IF/ID flush.
- Returns a registered training update to the predictor.

Parameters:
- AW, 32, PC/address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- StallD  in  1  hold the D-stage prediction register
- FlushD  in  1  external bubble into D (hazard unit)
- PreBrF  in  1  fetch-time predict-taken flag
- PCPredictF  in  AW  fetch-time predicted target
- PCPlus4F  in  AW  fall-through PC of the fetched instruction
- BranchD  in  1  D-stage instruction is a conditional branch
- BrTakenD  in  1  actual branch outcome in D
- PCBranchD  in  AW  actual branch target computed in D
- MispredD  out  1  misprediction detected this cycle (combinational)
- RedirectPCD  out  AW  corrected fetch PC, valid while MispredD=1
- FlushFD  out  1  squash the wrong-path instruction in IF/ID
- UpdEn  out  1  one-cycle predictor training pulse (registered)
- UpdTaken  out  1  actual outcome for training
- UpdTarget  out  AW  actual target for training
- BrCnt  out  CNT_W  branches resolved
- MissCnt  out  CNT_W  mispredictions

Behaviour:
- All state updates on posedge clk only. rst_n=0 at an edge clears all state and all registered outputs; mid-operation reset discards any pending redirect or update.
- D-stage prediction register {preD, predPCD, pc4D}:
  - Loads {PreBrF, PCPredictF, PCPlus4F} when StallD=0.
  - Clears to 0 when FlushD=1 or FlushFD=1. Flush has priority over stall.
- Resolution is qualified: res = BranchD & ~StallD & (state==RUN).
- Mispredict cases (MispredD = res & any case):
  - preD=1, BrTakenD=0 -> RedirectPCD=pc4D.
  - preD=0, BrTakenD=1 -> RedirectPCD=PCBranchD.
  - preD=1, BrTakenD=1, predPCD!=PCBranchD -> RedirectPCD=PCBranchD.
- Non-mispredict outputs:
  - RedirectPCD=0 when MispredD=0.
  - FlushFD=MispredD.
- State machine, 2 states:
  - RUN: on MispredD go to RECOVER.
  - RECOVER: lasts exactly one cycle. The D instruction is wrong-path, so no resolution, no update and no counting. Then return to RUN. StallD in RECOVER holds the state.
- Training:
  - On any res, in the next cycle UpdEn=1, UpdTaken=BrTakenD, UpdTarget=PCBranchD.
  - UpdEn is otherwise 0. Registered outputs hold their last value when UpdEn=0.
- Counters:
  - BrCnt increments on res; MissCnt increments on MispredD.
  - Both saturate at all-ones and never wrap.
- Reset values: MispredD=0, RedirectPCD=0, FlushFD=0, UpdEn=0, UpdTaken=0, UpdTarget=0, BrCnt=0, MissCnt=0, state=RUN.
- A branch held under StallD resolves once only, in the first cycle with StallD=0.

Optional Feature:
- BRU_PERF_CNT_EN defined: BrCnt/MissCnt are implemented as above.
- Not defined: no counter flops exist and BrCnt/MissCnt are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - AW default.
  - Branch opcode constants (BEQ 6'h4, BNE 6'h5, BLEZ 6'h6, BGTZ 6'h7, REGIMM 6'h1).
  - State encoding RUN=1'b0, RECOVER=1'b1.
- One natural sub-module: bru_sat_counter (CNT_W, inc, synchronous clear). Instantiated twice under BRU_PERF_CNT_EN.

Test Plan:
- Correct not-taken: PreBrF=0 loaded; next cycle BranchD=1, BrTakenD=0 -> MispredD=0, FlushFD=0; following cycle UpdEn=1, UpdTaken=0; BrCnt=1, MissCnt=0.
- Wrong taken: PreBrF=1, PCPlus4F=0x104; D: BrTakenD=0 -> MispredD=1, RedirectPCD=0x104, FlushFD=1; next cycle state RECOVER, and BranchD=1 in that cycle -> no UpdEn for it, MissCnt=1.
- Target mismatch: PreBrF=1, PCPredictF=0x200; D: BrTakenD=1, PCBranchD=0x240 -> RedirectPCD=0x240, MispredD=1; UpdTarget=0x240 next cycle.
- Stall: branch in D with StallD=1 for 3 cycles, then released -> exactly one UpdEn pulse and BrCnt increments by 1.
- Saturation and reset: force 2^CNT_W+5 mispredictions -> MissCnt=0xFFFF for CNT_W=16; rst_n=0 during RECOVER -> all outputs 0 and state RUN at the next edge.
- Macro off: rerun the wrong-taken scenario without BRU_PERF_CNT_EN -> BrCnt=MissCnt=0, redirect behaviour identical.
